// File: rtl/mux_n_1_stream.sv
// N:1 stream mux with valid/ready handshake and a single registered output stage.
// MODE 0 selects the channel with sel; MODE 1 arbitrates round-robin.
module mux_n_1_stream #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned MODE   = 0,
  parameter int unsigned SW     = $clog2(NUM_IN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NUM_IN*DW-1:0] in_data,
  input  logic [NUM_IN-1:0]    in_valid,
  output logic [NUM_IN-1:0]    in_ready,
  input  logic [SW-1:0]        sel,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_idx
);

  logic          can_load;
  logic          xfer;
  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] hi_grant;
  logic [SW-1:0] lo_grant;
  logic          hi_found;
  logic          lo_found;
  logic [SW-1:0] grant;
  logic          grant_ok;
  logic [DW-1:0] grant_data;

  assign can_load = !out_valid || out_ready;

  // Round-robin search: lowest valid channel at or above rr_ptr, else lowest valid overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    hi_grant = '0;
    lo_found = 1'b0;
    lo_grant = '0;
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_found = 1'b1;
        lo_grant = SW'(i);
        if (SW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_grant = SW'(i);
        end
      end
    end
  end

  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (MODE == 0) begin
      grant    = sel;
      grant_ok = 1'b1;
    end else begin
      grant    = hi_found ? hi_grant : lo_grant;
      grant_ok = lo_found;
    end
  end

  // Out-of-range sel matches no channel, so nothing is ready
  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grant == SW'(i)) begin
        in_ready[i] = grant_ok && can_load && !flush;
        grant_data  = in_data[i*DW +: DW];
      end
    end
  end

  assign xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_idx   <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Pointer advances past the granted channel only on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if ((MODE != 0) && xfer && !flush) begin
      rr_ptr <= (grant == SW'(NUM_IN - 1)) ? '0 : grant + SW'(1);
    end
  end

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Bench for mux_n_1_stream: select-mode (4 and 3 channels) and round-robin instances
// driven in parallel and checked against a queue-free behavioural model.
module tb_mux_n_1_stream;
  localparam int unsigned DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic flush = 1'b0;
  logic out_ready = 1'b0;
  logic [4*DW-1:0] in_data = '0;
  logic [3:0] in_valid = '0;
  logic [1:0] sel = '0;

  logic [3:0] r0, r1;
  logic [2:0] r2;
  logic [DW-1:0] d0, d1, d2;
  logic v0, v1, v2;
  logic [1:0] i0, i1, i2;

  logic [3:0]    a_rdy [NI];
  logic [DW-1:0] a_d   [NI];
  logic          a_v   [NI];
  logic [1:0]    a_i   [NI];

  int checks = 0;
  int errors = 0;

  bit          m_v  [NI];
  logic [31:0] m_d  [NI];
  int          m_i  [NI];
  int          m_rr [NI];

  always #5 clk = ~clk;

  mux_n_1_stream #(.DW(DW), .NUM_IN(4), .MODE(0)) u_sel4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r0), .sel(sel), .out_data(d0), .out_valid(v0), .out_ready(out_ready), .out_idx(i0));

  mux_n_1_stream #(.DW(DW), .NUM_IN(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(r1), .sel(sel), .out_data(d1), .out_valid(v1), .out_ready(out_ready), .out_idx(i1));

  mux_n_1_stream #(.DW(DW), .NUM_IN(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data[3*DW-1:0]), .in_valid(in_valid[2:0]),
    .in_ready(r2), .sel(sel), .out_data(d2), .out_valid(v2), .out_ready(out_ready), .out_idx(i2));

  always_comb begin
    a_rdy[0] = r0; a_rdy[1] = r1; a_rdy[2] = {1'b0, r2};
    a_d[0] = d0;   a_d[1] = d1;   a_d[2] = d2;
    a_v[0] = v0;   a_v[1] = v1;   a_v[2] = v2;
    a_i[0] = i0;   a_i[1] = i1;   a_i[2] = i2;
  end

  task automatic chk(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h want %h", nm, j, $time, act, exp);
    end
  endtask

  function automatic int nch(input int j);
    return (j == 2) ? 3 : 4;
  endfunction

  // Which channel the rules pick this cycle, and whether any channel is eligible
  function automatic void plan(input int j, output int g, output bit has);
    int n;
    n = nch(j);
    g = 0;
    has = 1'b0;
    if (j != 1) begin
      g = int'(sel);
      has = (g < n);
    end else begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m_rr[j] + k) % n;
        if (!has && in_valid[c]) begin
          has = 1'b1;
          g = c;
        end
      end
    end
  endfunction

  // Per-cycle compare, then advance the model to the state after the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NI; j++) begin
        chk("rst_valid", j, 32'(a_v[j]), 32'd0);
        chk("rst_idx", j, 32'(a_i[j]), 32'd0);
        chk("rst_data", j, a_d[j], 32'd0);
        m_v[j] = 1'b0; m_d[j] = '0; m_i[j] = 0; m_rr[j] = 0;
      end
    end else begin
      for (int j = 0; j < NI; j++) begin
        int g;
        bit has;
        logic [3:0] er;
        bit xfer;
        plan(j, g, has);
        er = (has && (!m_v[j] || out_ready) && !flush) ? (4'b0001 << g) : 4'b0000;
        xfer = (er & in_valid) != 4'b0000;
        chk("in_ready", j, 32'(a_rdy[j]), 32'(er));
        chk("out_valid", j, 32'(a_v[j]), 32'(m_v[j]));
        chk("out_idx", j, 32'(a_i[j]), 32'(m_i[j]));
        chk("out_data", j, a_d[j], m_d[j]);
        if (flush) begin
          m_v[j] = 1'b0;
        end else if (xfer) begin
          m_v[j] = 1'b1;
          m_d[j] = in_data[g*DW +: DW];
          m_i[j] = g;
          if (j == 1) m_rr[j] = (g + 1) % nch(j);
        end else if (out_ready) begin
          m_v[j] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tagged_data();
    for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);
  endtask

  task automatic set_random_data();
    for (int k = 0; k < 4; k++) in_data[k*DW +: DW] = $urandom;
  endtask

  initial begin
    logic [1:0] seq [6];
    logic [DW-1:0] held_d;
    logic [1:0] held_i;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0; seq[5] = 2'd1;

    #2 rst_n = 1'b0;
    @(posedge clk);
    tick();
    rst_n = 1'b1;

    // Select mode picks ch2; round-robin starts at ch0
    set_tagged_data();
    in_valid = 4'hF; sel = 2'd2; out_ready = 1'b1;
    #1;
    chk("lit_ready_sel", 0, 32'(r0), 32'h4);
    chk("lit_ready_rr", 1, 32'(r1), 32'h1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("lit_rr_seq", 1, 32'(i1), 32'(seq[c]));
      chk("lit_rr_valid", 1, 32'(v1), 32'd1);
      if (c == 0) begin
        chk("lit_sel_data", 0, d0, 32'hA5A5_0002);
        chk("lit_sel_idx", 0, 32'(i0), 32'd2);
        chk("lit_sel_valid", 0, 32'(v0), 32'd1);
      end
    end

    // Pointer now 2: a lone ch0 request moves it to 1, then {3,0} alternates with wrap
    in_valid = 4'b0001;
    tick();
    chk("lit_rr_lone0", 1, 32'(i1), 32'd0);
    in_valid = 4'b1001;
    tick(); chk("lit_rr_wrap_a", 1, 32'(i1), 32'd3);
    tick(); chk("lit_rr_wrap_b", 1, 32'(i1), 32'd0);
    tick(); chk("lit_rr_wrap_c", 1, 32'(i1), 32'd3);

    // Stall with changing inputs, then back-to-back reload
    in_valid = 4'hF; sel = 2'd1; out_ready = 1'b1;
    tick();
    held_d = d0; held_i = i0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_random_data();
      sel = 2'(c + 2);
      #1;
      chk("lit_stall_ready", 0, 32'(r0), 32'd0);
      chk("lit_stall_ready", 1, 32'(r1), 32'd0);
      tick();
      chk("lit_stall_data", 0, d0, held_d);
      chk("lit_stall_idx", 0, 32'(i0), 32'(held_i));
      chk("lit_stall_valid", 0, 32'(v0), 32'd1);
    end
    set_tagged_data();
    sel = 2'd3; out_ready = 1'b1;
    #1;
    chk("lit_sel3_oob", 2, 32'(r2), 32'd0);
    tick();
    chk("lit_reload_data", 0, d0, 32'hA5A5_0003);
    chk("lit_reload_idx", 0, 32'(i0), 32'd3);
    chk("lit_reload_rr", 1, 32'(i1), 32'd1);

    // Flush blocks acceptance, clears valid, keeps the pointer
    flush = 1'b1;
    #1;
    chk("lit_flush_ready", 0, 32'(r0), 32'd0);
    chk("lit_flush_ready", 1, 32'(r1), 32'd0);
    tick();
    chk("lit_flush_valid", 0, 32'(v0), 32'd0);
    chk("lit_flush_valid", 1, 32'(v1), 32'd0);
    flush = 1'b0;
    tick();
    chk("lit_flush_ptr", 1, 32'(i1), 32'd2);

    // Asynchronous reset while holding a valid entry
    out_ready = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("lit_arst_valid", 1, 32'(v1), 32'd0);
    chk("lit_arst_idx", 1, 32'(i1), 32'd0);
    chk("lit_arst_valid", 0, 32'(v0), 32'd0);
    tick();
    rst_n = 1'b1;
    in_valid = 4'hF; out_ready = 1'b1;
    tick();
    chk("lit_arst_first", 1, 32'(i1), 32'd0);
    chk("lit_arst_first_v", 1, 32'(v1), 32'd1);

    // Randomized traffic checked by the model
    for (int c = 0; c < 2000; c++) begin
      set_random_data();
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
